// File: rtl/eth_rx_fcs_check.sv
// rtl/eth_rx_fcs_check.sv - MII receive framer with nibble-wide CRC-32 FCS check
// Strips preamble/SFD and the trailing FCS, emits payload bytes and one status pulse per frame.

module crc32_4bit (
   input  logic [31:0] i_crc,
   input  logic [3:0]  i_nibble,
   output logic [31:0] o_crc
);
   localparam logic [31:0] POLY = 32'hEDB88320;

   logic [31:0] w_c;

   always_comb begin
      w_c = i_crc ^ {28'd0, i_nibble};
      for (int i = 0; i < 4; i++) begin
         w_c = w_c[0] ? ((w_c >> 1) ^ POLY) : (w_c >> 1);
      end
      o_crc = w_c;
   end
endmodule

module eth_rx_fcs_check (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_in_en,
   input  logic        i_in_dv,
   input  logic        i_in_er,
   input  logic [3:0]  i_in_nibble,
   output logic        o_out_valid,
   output logic [7:0]  o_out_data,
   output logic        o_frame_done,
   output logic        o_frame_ok,
   output logic        o_crc_err,
   output logic        o_align_err,
   output logic        o_rx_err,
   output logic        o_runt,
   output logic        o_too_long,
   output logic [10:0] o_byte_count
);
   localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
   localparam logic [10:0] MIN_BYTES   = 11'd64;
   localparam logic [10:0] MAX_BYTES   = 11'd1522;
   localparam logic [10:0] BYTES_SAT   = 11'd2047;
   localparam logic [10:0] FCS_BYTES   = 11'd4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_DATA,
      ST_DROP
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic        w_sfd;
   logic        w_nib;
   logic        w_eof;

   logic [31:0] r_crc;
   logic [31:0] w_crc_next;
   logic        r_phase;
   logic [3:0]  r_low;
   logic [10:0] r_bytes;
   logic [31:0] r_dl;
   logic [2:0]  r_dl_cnt;
   logic        r_rx_err;

   logic        w_crc_err;
   logic        w_runt;
   logic        w_too_long;
   logic        w_rx_err;
   logic [10:0] w_count;

   crc32_4bit u_crc (
      .i_crc    (r_crc),
      .i_nibble (i_in_nibble),
      .o_crc    (w_crc_next)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= ST_DROP;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      w_sfd  = 1'b0;
      w_nib  = 1'b0;
      w_eof  = 1'b0;
      if (i_in_en) begin
         case (r_state)
            ST_IDLE: begin
               if (i_in_dv) begin
                  w_next = (i_in_nibble == 4'h5) ? ST_PREAMBLE : ST_DROP;
               end
            end
            ST_PREAMBLE: begin
               if (!i_in_dv) begin
                  w_next = ST_IDLE;
               end else if (i_in_nibble == 4'hD) begin
                  w_next = ST_DATA;
                  w_sfd  = 1'b1;
               end else if (i_in_nibble != 4'h5) begin
                  w_next = ST_DROP;
               end
            end
            ST_DATA: begin
               if (i_in_dv) begin
                  w_nib = 1'b1;
               end else begin
                  w_next = ST_IDLE;
                  w_eof  = 1'b1;
               end
            end
            default: begin
               if (!i_in_dv) begin
                  w_next = ST_IDLE;
               end
            end
         endcase
      end
   end

   // Verdict is formed from the state as it stands on the in_dv=0 nibble.
   always_comb begin
      w_crc_err  = (r_crc != CRC_RESIDUE);
      w_runt     = (r_bytes < MIN_BYTES);
      w_too_long = (r_bytes > MAX_BYTES);
      w_rx_err   = r_rx_err | i_in_er;
      w_count    = (r_bytes < FCS_BYTES) ? 11'd0 : (r_bytes - FCS_BYTES);
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_crc        <= 32'hFFFFFFFF;
         r_phase      <= 1'b0;
         r_low        <= 4'd0;
         r_bytes      <= 11'd0;
         r_dl         <= 32'd0;
         r_dl_cnt     <= 3'd0;
         r_rx_err     <= 1'b0;
         o_out_valid  <= 1'b0;
         o_out_data   <= 8'd0;
         o_frame_done <= 1'b0;
         o_frame_ok   <= 1'b0;
         o_crc_err    <= 1'b0;
         o_align_err  <= 1'b0;
         o_rx_err     <= 1'b0;
         o_runt       <= 1'b0;
         o_too_long   <= 1'b0;
         o_byte_count <= 11'd0;
      end else begin
         o_out_valid  <= 1'b0;
         o_frame_done <= 1'b0;

         if (w_sfd) begin
            r_crc    <= 32'hFFFFFFFF;
            r_phase  <= 1'b0;
            r_bytes  <= 11'd0;
            r_dl_cnt <= 3'd0;
            r_rx_err <= 1'b0;
         end

         if (w_nib) begin
            r_crc   <= w_crc_next;
            r_phase <= ~r_phase;
            if (i_in_er) begin
               r_rx_err <= 1'b1;
            end
            if (!r_phase) begin
               r_low <= i_in_nibble;
            end else begin
               if (r_bytes != BYTES_SAT) begin
                  r_bytes <= r_bytes + 11'd1;
               end
               // Four-byte delay line holds back what may turn out to be the FCS.
               r_dl <= {r_dl[23:0], i_in_nibble, r_low};
               if (r_dl_cnt == 3'd4) begin
                  o_out_valid <= 1'b1;
                  o_out_data  <= r_dl[31:24];
               end else begin
                  r_dl_cnt <= r_dl_cnt + 3'd1;
               end
            end
         end

         if (w_eof) begin
            r_dl_cnt     <= 3'd0;
            o_frame_done <= 1'b1;
            o_crc_err    <= w_crc_err;
            o_align_err  <= r_phase;
            o_rx_err     <= w_rx_err;
            o_runt       <= w_runt;
            o_too_long   <= w_too_long;
            o_byte_count <= w_count;
            o_frame_ok   <= ~(w_crc_err | r_phase | w_rx_err | w_runt | w_too_long);
         end
      end
   end
endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// tb/tb_eth_rx_fcs_check.sv - randomized scoreboard bench for eth_rx_fcs_check
// Expected bytes/status are queued at stimulus time and popped by an independent monitor.

module tb_eth_rx_fcs_check;
   localparam logic [31:0] POLY    = 32'hEDB88320;
   localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

   typedef logic [7:0] byte_q_t[$];
   typedef struct {
      int         fid;
      logic [7:0] b;
   } exp_byte_t;
   typedef struct {
      int          fid;
      logic        ok;
      logic        crc;
      logic        align;
      logic        rx;
      logic        runt;
      logic        tl;
      logic [10:0] cnt;
   } exp_stat_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_en;
   logic        in_dv;
   logic        in_er;
   logic [3:0]  in_nib;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        frame_done;
   logic        frame_ok;
   logic        crc_err;
   logic        align_err;
   logic        rx_err;
   logic        runt;
   logic        too_long;
   logic [10:0] byte_count;

   exp_byte_t exp_bytes[$];
   exp_stat_t exp_stats[$];
   int        checks = 0;
   int        errors = 0;
   int        next_fid = 0;

   eth_rx_fcs_check dut (
      .i_clk        (clk),
      .i_reset      (reset),
      .i_in_en      (in_en),
      .i_in_dv      (in_dv),
      .i_in_er      (in_er),
      .i_in_nibble  (in_nib),
      .o_out_valid  (out_valid),
      .o_out_data   (out_data),
      .o_frame_done (frame_done),
      .o_frame_ok   (frame_ok),
      .o_crc_err    (crc_err),
      .o_align_err  (align_err),
      .o_rx_err     (rx_err),
      .o_runt       (runt),
      .o_too_long   (too_long),
      .o_byte_count (byte_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Bit-serial reference CRC, data bits taken LSB first as they go on the wire.
   function automatic logic [31:0] crc_bits(input logic [31:0] c, input logic [7:0] v, input int nbits);
      logic fb;
      for (int i = 0; i < nbits; i++) begin
         fb = c[0] ^ v[i];
         c  = c >> 1;
         if (fb) c = c ^ POLY;
      end
      return c;
   endfunction

   function automatic byte_q_t add_fcs(input byte_q_t d);
      logic [31:0] c;
      byte_q_t     r;
      r = d;
      c = 32'hFFFFFFFF;
      foreach (d[i]) c = crc_bits(c, d[i], 8);
      c = ~c;
      r.push_back(c[7:0]);
      r.push_back(c[15:8]);
      r.push_back(c[23:16]);
      r.push_back(c[31:24]);
      return r;
   endfunction

   task automatic nib(input logic dv, input logic er, input logic [3:0] n);
      int gap;
      gap = $urandom_range(0, 2);
      in_en = 1'b0;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      in_en  = 1'b1;
      in_dv  = dv;
      in_er  = er;
      in_nib = n;
      @(posedge clk);
      #1;
      in_en = 1'b0;
      in_er = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("reset_mid_frame_ok", frame_ok, 0);
      check("reset_mid_frame_count", byte_count, 0);
      check("reset_mid_frame_valid", out_valid, 0);
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input byte_q_t data, input bit odd, input int er_byte,
                             input int rst_byte, input bit bad_pre);
      int          n;
      int          fid;
      logic [31:0] c;
      exp_stat_t   s;
      exp_byte_t   eb;
      n   = data.size();
      fid = next_fid;
      next_fid++;
      if (bad_pre) begin
      end else if (rst_byte >= 0) begin
         for (int i = 0; i < rst_byte - 4; i++) begin
            eb.fid = fid;
            eb.b   = data[i];
            exp_bytes.push_back(eb);
         end
      end else begin
         for (int i = 0; i < n - 4; i++) begin
            eb.fid = fid;
            eb.b   = data[i];
            exp_bytes.push_back(eb);
         end
         c = 32'hFFFFFFFF;
         for (int i = 0; i < n; i++) c = crc_bits(c, data[i], 8);
         if (odd) c = crc_bits(c, 8'h07, 4);
         s.fid   = fid;
         s.crc   = (c != RESIDUE);
         s.align = odd;
         s.rx    = (er_byte >= 0);
         s.runt  = (n < 64);
         s.tl    = (n > 1522);
         s.cnt   = (n < 4) ? 11'd0 : 11'(n - 4);
         s.ok    = !(s.crc || s.align || s.rx || s.runt || s.tl);
         exp_stats.push_back(s);
      end
      for (int i = 0; i < 15; i++) begin
         nib(1'b1, 1'b0, 4'h5);
         if (bad_pre && i == 3) nib(1'b1, 1'b0, 4'hA);
      end
      nib(1'b1, 1'b0, 4'hD);
      for (int i = 0; i < n; i++) begin
         if (i == rst_byte) do_reset();
         nib(1'b1, i == er_byte, data[i][3:0]);
         nib(1'b1, i == er_byte, data[i][7:4]);
      end
      if (odd) nib(1'b1, 1'b0, 4'h7);
      nib(1'b0, 1'b0, 4'h0);
   endtask

   initial begin
      exp_stat_t st;
      forever begin
         @(negedge clk);
         if (out_valid) begin
            checks++;
            if (exp_bytes.size() == 0) begin
               errors++;
               $display("FAIL unexpected_byte: got 0x%0h, expected no output", out_data);
            end else begin
               if (out_data != exp_bytes[0].b) begin
                  errors++;
                  $display("FAIL out_data frame %0d: got 0x%0h, expected 0x%0h",
                           exp_bytes[0].fid, out_data, exp_bytes[0].b);
               end
               void'(exp_bytes.pop_front());
            end
         end
         if (frame_done) begin
            checks++;
            if (exp_stats.size() == 0) begin
               errors++;
               $display("FAIL unexpected_frame_done: got frame_done=1 count=%0d, expected none", byte_count);
            end else begin
               st = exp_stats.pop_front();
               if (exp_bytes.size() > 0 && exp_bytes[0].fid == st.fid) begin
                  errors++;
                  $display("FAIL bytes_pending_at_done frame %0d: got %0d left, expected 0", st.fid, exp_bytes.size());
               end
               check("frame_ok", frame_ok, st.ok);
               check("crc_err", crc_err, st.crc);
               check("align_err", align_err, st.align);
               check("rx_err", rx_err, st.rx);
               check("runt", runt, st.runt);
               check("too_long", too_long, st.tl);
               check("byte_count", byte_count, st.cnt);
            end
         end
      end
   end

   initial begin
      byte_q_t good;
      byte_q_t p;
      int      len;
      reset  = 1'b1;
      in_en  = 1'b0;
      in_dv  = 1'b0;
      in_er  = 1'b0;
      in_nib = 4'h0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_frame_ok", frame_ok, 0);
      check("rst_crc_err", crc_err, 0);
      check("rst_align_err", align_err, 0);
      check("rst_rx_err", rx_err, 0);
      check("rst_runt", runt, 0);
      check("rst_too_long", too_long, 0);
      check("rst_byte_count", byte_count, 0);
      @(posedge clk);
      #1;
      nib(1'b0, 1'b0, 4'h0);

      p = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
           8'h26, 8'h39, 8'hF4, 8'hCB};
      send_frame(p, 1'b0, -1, -1, 1'b0);

      good = {};
      for (int i = 0; i < 60; i++) good.push_back(8'(i));
      good = add_fcs(good);
      send_frame(good, 1'b0, -1, -1, 1'b0);
      p = good;
      p[10] = p[10] ^ 8'h01;
      send_frame(p, 1'b0, -1, -1, 1'b0);
      send_frame(good, 1'b1, -1, -1, 1'b0);
      send_frame(good, 1'b0, 20, -1, 1'b0);

      p = {};
      for (int i = 0; i < 1519; i++) p.push_back(8'($urandom));
      p = add_fcs(p);
      send_frame(p, 1'b0, -1, -1, 1'b0);
      send_frame(good, 1'b0, -1, -1, 1'b0);

      send_frame(good, 1'b0, -1, 30, 1'b0);
      send_frame(good, 1'b0, -1, -1, 1'b0);
      send_frame(good, 1'b0, -1, -1, 1'b1);
      send_frame(good, 1'b0, -1, -1, 1'b0);

      p = {8'hAA, 8'h55};
      send_frame(p, 1'b0, -1, -1, 1'b0);
      p = {};
      send_frame(p, 1'b0, -1, -1, 1'b0);
      p = {};
      for (int i = 0; i < 59; i++) p.push_back(8'($urandom));
      p = add_fcs(p);
      send_frame(p, 1'b0, -1, -1, 1'b0);

      for (int f = 0; f < 6; f++) begin
         len = $urandom_range(30, 100);
         p = {};
         for (int i = 0; i < len; i++) p.push_back(8'($urandom));
         p = add_fcs(p);
         if ($urandom_range(0, 3) == 0) p[$urandom_range(0, len - 1)] ^= 8'h10;
         send_frame(p, $urandom_range(0, 3) == 0,
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1,
                    -1, 1'b0);
      end

      repeat (20) @(posedge clk);
      @(negedge clk);
      check("bytes_left_at_end", exp_bytes.size(), 0);
      check("status_left_at_end", exp_stats.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
